// File: rtl/fpu_pkg.sv
// Shared encodings for the FP issue path: opcodes, rounding modes, exception
// flag positions and the issue arbiter's run/drain state.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Same 2-bit encoding the rounding stage decodes.
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag word.
  localparam int EXC_W  = 5;
  localparam int EXC_NX = 0;
  localparam int EXC_UF = 1;
  localparam int EXC_OF = 2;
  localparam int EXC_DZ = 3;
  localparam int EXC_NV = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fpu_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant scanning from ptr, pointer moves
// past the winner whenever the caller signals that the grant was taken.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one fixed-latency FP pipeline among NUM_REQ requesters: round-robin
// issue, tag shift register for result routing, per-requester credit and drain.
module fpu_issue_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 5,
  parameter int MAX_OUT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [2*NUM_REQ-1:0] req_mode,
  output logic                 pipe_valid,
  output logic [31:0]          pipe_a,
  output logic [31:0]          pipe_b,
  output logic [1:0]           pipe_op,
  output logic [1:0]           pipe_mode,
  input  logic                 pipe_res_valid,
  input  logic [31:0]          pipe_result,
  input  logic [EXC_W-1:0]     pipe_exc,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [31:0]          resp_data,
  output logic [EXC_W-1:0]     resp_exc,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic                 busy,
  output logic                 err_mismatch
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0] eligible, grant, retire_hit;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;

  logic [CW-1:0] cnt_q [NUM_REQ];
  logic [CW-1:0] cnt_d [NUM_REQ];

  logic          pipe_valid_q, pipe_valid_d;
  logic [IW-1:0] pipe_id_q, pipe_id_d;
  logic [31:0]   pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;
  logic [1:0]    pipe_op_q, pipe_op_d, pipe_mode_q, pipe_mode_d;

  logic [PIPE_LAT-1:0] tag_v_q, tag_v_d;
  logic [IW-1:0]       tag_id_q [PIPE_LAT];
  logic [IW-1:0]       tag_id_d [PIPE_LAT];
  logic                tail_v;
  logic [IW-1:0]       tail_id;

  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic [EXC_W-1:0]   resp_exc_q, resp_exc_d;
  logic               err_q, err_d;
  logic               cnt_busy;

  // Reset gates eligibility so req_ready is low while rst is held.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = !rst && req_valid[i] && (cnt_q[i] < CW'(MAX_OUT)) &&
                    (state_q == RUN) && (req_op[2*i +: 2] != OP_RSV);
    end
  end

  assign grant_any = |grant;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible),
    .advance   (grant_any),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign tail_v  = tag_v_q[PIPE_LAT-1];
  assign tail_id = tag_id_q[PIPE_LAT-1];

  always_comb begin
    pipe_valid_d = grant_any;
    pipe_id_d    = grant_idx;
    pipe_a_d     = pipe_a_q;
    pipe_b_d     = pipe_b_q;
    pipe_op_d    = pipe_op_q;
    pipe_mode_d  = pipe_mode_q;
    if (grant_any) begin
      pipe_a_d    = req_a[32*grant_idx +: 32];
      pipe_b_d    = req_b[32*grant_idx +: 32];
      pipe_op_d   = req_op[2*grant_idx +: 2];
      pipe_mode_d = req_mode[2*grant_idx +: 2];
    end

    // Stage 0 is fed from the issue register, so the tail lines up with the
    // result PIPE_LAT cycles after the pipeline samples pipe_valid.
    tag_v_d[0]  = pipe_valid_q;
    tag_id_d[0] = pipe_id_q;
    for (int k = 1; k < PIPE_LAT; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end

    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_exc_d   = resp_exc_q;
    if (tail_v && pipe_res_valid) begin
      resp_valid_d[tail_id] = 1'b1;
      resp_data_d           = pipe_result;
      resp_exc_d            = pipe_exc;
    end
    err_d = err_q | (tail_v ^ pipe_res_valid);

    // A tail without a result still returns its credit.
    cnt_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      retire_hit[i] = tail_v && (tail_id == IW'(i));
      cnt_d[i]      = cnt_q[i];
      if (grant[i] && !retire_hit[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!grant[i] && retire_hit[i]) cnt_d[i] = cnt_q[i] - CW'(1);
      cnt_busy = cnt_busy | (cnt_q[i] != '0);
    end
  end

  assign busy = (|tag_v_q) || cnt_busy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (!drain_req) state_d = RUN;
               else if (!busy) state_d = IDLE;
      IDLE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pipe_valid_q <= 1'b0;
      pipe_id_q    <= '0;
      pipe_a_q     <= '0;
      pipe_b_q     <= '0;
      pipe_op_q    <= '0;
      pipe_mode_q  <= '0;
      tag_v_q      <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_id_q[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++)  cnt_q[i]    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_exc_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_id_q    <= pipe_id_d;
      pipe_a_q     <= pipe_a_d;
      pipe_b_q     <= pipe_b_d;
      pipe_op_q    <= pipe_op_d;
      pipe_mode_q  <= pipe_mode_d;
      tag_v_q      <= tag_v_d;
      for (int k = 0; k < PIPE_LAT; k++) tag_id_q[k] <= tag_id_d[k];
      for (int i = 0; i < NUM_REQ; i++)  cnt_q[i]    <= cnt_d[i];
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_exc_q   <= resp_exc_d;
      err_q        <= err_d;
    end
  end

  assign req_ready    = grant;
  assign pipe_valid   = pipe_valid_q;
  assign pipe_a       = pipe_a_q;
  assign pipe_b       = pipe_b_q;
  assign pipe_op      = pipe_op_q;
  assign pipe_mode    = pipe_mode_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_exc     = resp_exc_q;
  assign drain_done   = (state_q == IDLE);
  assign err_mismatch = err_q;

endmodule
